// File: rtl/sw_debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
package sw_debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW  = 2'b00,
        ST_L2H  = 2'b01,
        ST_HIGH = 2'b10,
        ST_H2L  = 2'b11
    } deb_state_t;

    localparam int DEB_STABLE_CYCLES_DEF = 500000;

endpackage

// File: rtl/sw_debounce_sync_2ff.sv
// Single-bit two-flop synchronizer, async active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_reg <= 1'b0;
            q_reg    <= 1'b0;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/sw_debounce.sv
// Switch debouncer: synchronize, time stability, emit clean level and edge pulses.
// Optional macro DEBOUNCE_SYNC_EN selects a two-flop synchronizer instead of one sampling flop.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEB_STABLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_in,
    output logic sw_clean,
    output logic sw_rise,
    output logic sw_fall,
    output logic busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic s;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw_in),
        .q     (s)
    );
`else
    logic sample_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_reg <= 1'b0;
        end else begin
            sample_reg <= sw_in;
        end
    end

    assign s = sample_reg;
`endif

    deb_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             clean_reg, clean_next;
    logic             rise_reg, rise_next;
    logic             fall_reg, fall_next;
    logic             busy_reg, busy_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_LOW;
            cnt_reg   <= '0;
            clean_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            clean_reg <= clean_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
            busy_reg  <= busy_next;
        end
    end

    // cnt_reg holds how many new-level samples have been seen so far; the
    // sample that brings it to STABLE_CYCLES is accepted instead of stored.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        clean_next = clean_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;

        case (state_reg)
            ST_LOW: begin
                cnt_next = '0;
                if (s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_next = ST_HIGH;
                        clean_next = 1'b1;
                        rise_next  = 1'b1;
                    end else begin
                        state_next = ST_L2H;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            ST_L2H: begin
                if (!s) begin
                    state_next = ST_LOW;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_HIGH;
                    cnt_next   = '0;
                    clean_next = 1'b1;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ST_HIGH: begin
                cnt_next = '0;
                if (!s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_next = ST_LOW;
                        clean_next = 1'b0;
                        fall_next  = 1'b1;
                    end else begin
                        state_next = ST_H2L;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            ST_H2L: begin
                if (s) begin
                    state_next = ST_HIGH;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_LOW;
                    cnt_next   = '0;
                    clean_next = 1'b0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = ST_LOW;
                cnt_next   = '0;
                clean_next = 1'b0;
            end
        endcase

        busy_next = (state_next == ST_L2H) || (state_next == ST_H2L);
    end

    assign sw_clean = clean_reg;
    assign sw_rise  = rise_reg;
    assign sw_fall  = fall_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with STABLE_CYCLES=4; latency follows DEBOUNCE_SYNC_EN.
module tb_sw_debounce;

    localparam int SC = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    // Edge (counted from the first edge sampling the new level) where the level is accepted.
    localparam int ACC = SC + LAT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sw_in = 1'b0;
    logic sw_clean, sw_rise, sw_fall, busy;
    logic [3:0] outs;

    int n_cmp = 0;
    int n_err = 0;

    sw_debounce #(.STABLE_CYCLES(SC)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_in    (sw_in),
        .sw_clean (sw_clean),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .busy     (busy)
    );

    assign outs = {sw_clean, sw_rise, sw_fall, busy};

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected {clean, rise, fall, busy} e edges after sw_in goes 0->1 from a quiet low.
    function automatic logic [3:0] rise_exp(input int e);
        logic c, r, b;
        c = (e >= ACC);
        r = (e == ACC);
        b = (e > LAT) && (e < ACC);
        return {c, r, 1'b0, b};
    endfunction

    task automatic run_rise(input string tag);
        for (int e = 1; e <= ACC + 3; e++) begin
            tick(1);
            check_val($sformatf("%s_e%0d", tag, e), 32'(outs), 32'(rise_exp(e)));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        logic [3:0] bounce;
        bounce = 4'b1010;  // applied MSB first as sw_in = 0,1,0,1

        // Reset state
        reset = 1'b1;
        sw_in = 1'b0;
        tick(3);
        check_val("reset_outs", 32'(outs), 32'h0);
        reset = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_val($sformatf("idle_c%0d", i), 32'(outs), 32'h0);
        end
        $display("scenario idle: done, compared=%0d", n_cmp);

        // 2: clean rise
        sw_in = 1'b1;
        run_rise("rise");
        tick(5);
        check_val("rise_settled", 32'(outs), 32'h8);
        $display("scenario rise: done, compared=%0d", n_cmp);

        // 4: bouncing fall
        for (int i = 0; i < 4; i++) begin
            sw_in = ~bounce[3-i];
            tick(1);
            check_val($sformatf("bounce_c%0d", i), 32'(outs[3:1]), 32'h4);
        end
        sw_in = 1'b0;
        for (int e = 1; e <= ACC + 3; e++) begin
            logic [2:0] exp3;
            tick(1);
            exp3 = {(e < ACC), 1'b0, (e == ACC)};
            check_val($sformatf("fall_e%0d", e), 32'(outs[3:1]), 32'(exp3));
            if (e == ACC - 1) check_val("fall_busy_pre", 32'(busy), 32'h1);
            if (e == ACC)     check_val("fall_busy_acc", 32'(busy), 32'h0);
        end
        tick(5);
        check_val("fall_settled", 32'(outs), 32'h0);
        $display("scenario bounce_fall: done, compared=%0d", n_cmp);

        // 3: 3-cycle glitch rejected
        sw_in = 1'b1;
        busy_cnt = 0;
        for (int e = 1; e <= 12; e++) begin
            tick(1);
            if (e == 3) sw_in = 1'b0;
            check_val($sformatf("glitch_e%0d", e), 32'(outs[3:1]), 32'h0);
            if (busy) busy_cnt++;
        end
        check_val("glitch_busy_cycles", 32'(busy_cnt), 32'd3);
        check_val("glitch_idle", 32'(outs), 32'h0);
        $display("scenario glitch: done, compared=%0d", n_cmp);

        // 5: reset mid-timing, then rise after release
        sw_in = 1'b1;
        tick(4);
        check_val("abort_busy_pre", 32'(outs), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_val("abort_async", 32'(outs), 32'h0);
        tick(2);
        check_val("abort_held", 32'(outs), 32'h0);
        reset = 1'b0;
        run_rise("post_reset");
        $display("scenario reset_abort: done, compared=%0d", n_cmp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
